niosv_soc_gpo_pulse: RTL and testbench



---
 rtl/niosv_soc_gpo_pulse.sv | 161 ++++++++++++++++
 tb/tb_niosv_soc_gpo_pulse.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/niosv_soc_gpo_pulse.sv
// niosv_soc_gpo_pulse
// Avalon-MM output port for the Nios V data bus. A software-written DATA
// register drives out_port. OUTSET/OUTCLEAR give atomic bit set/clear.
// A shared one-shot pulse engine inverts the selected bits for a programmed
// number of clocks.
module niosv_soc_gpo_pulse #(
  parameter int unsigned       DATA_W      = 4,
  parameter int unsigned       PULSE_W     = 16,
  parameter logic [DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_port
);

  typedef enum logic [2:0] {
    REG_DATA       = 3'd0,
    REG_PULSE_LEN  = 3'd1,
    REG_PULSE_TRIG = 3'd2,
    REG_STATUS     = 3'd3,
    REG_OUTSET     = 3'd4,
    REG_OUTCLEAR   = 3'd5,
    REG_RSVD6      = 3'd6,
    REG_RSVD7      = 3'd7
  } reg_addr_e;

  typedef enum logic {
    P_IDLE   = 1'b0,
    P_ACTIVE = 1'b1
  } pulse_state_e;

  // The STATUS counter field starts at bit 16 and cannot extend past bit 31.
  localparam int unsigned CNT_FIELD_W = (PULSE_W > 16) ? 16 : PULSE_W;
  localparam logic [PULSE_W-1:0] CNT_ONE = PULSE_W'(1);

  reg_addr_e          addr_sel;
  logic               wr;
  logic [DATA_W-1:0]  wd;
  logic               trig;

  logic [DATA_W-1:0]  data_reg;
  logic [DATA_W-1:0]  data_nxt;
  logic [PULSE_W-1:0] pulse_len;
  logic [PULSE_W-1:0] pulse_len_nxt;

  pulse_state_e       pulse_state;
  pulse_state_e       pulse_state_nxt;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [PULSE_W-1:0] pulse_cnt_nxt;
  logic [DATA_W-1:0]  pulse_mask;
  logic [DATA_W-1:0]  pulse_mask_nxt;
  logic               busy;

  logic [31:0]        rd_nxt;

  assign addr_sel = reg_addr_e'(address);
  assign wr       = chipselect & ~write_n;
  assign wd       = writedata[DATA_W-1:0];
  assign busy     = (pulse_cnt != '0);

  // A trigger with a zero length or an empty mask is a no-op.
  assign trig = wr && (addr_sel == REG_PULSE_TRIG) &&
                (pulse_len != '0) && (wd != '0);

  assign out_port = data_reg ^ pulse_mask;

  // Next value of the software-visible DATA and PULSE_LEN registers.
  always_comb begin
    data_nxt      = data_reg;
    pulse_len_nxt = pulse_len;
    if (wr) begin
      case (addr_sel)
        REG_DATA:      data_nxt      = wd;
        REG_PULSE_LEN: pulse_len_nxt = writedata[PULSE_W-1:0];
        REG_OUTSET:    data_nxt      = data_reg | wd;
        REG_OUTCLEAR:  data_nxt      = data_reg & ~wd;
        default:       ;
      endcase
    end
  end

  // Pulse engine next state: a trigger overrides the running decrement,
  // reloading the count and ORing new bits into the active mask.
  always_comb begin
    pulse_state_nxt = pulse_state;
    pulse_cnt_nxt   = pulse_cnt;
    pulse_mask_nxt  = pulse_mask;
    if (trig) begin
      pulse_state_nxt = P_ACTIVE;
      pulse_cnt_nxt   = pulse_len;
      pulse_mask_nxt  = pulse_mask | wd;
    end else begin
      case (pulse_state)
        P_ACTIVE: begin
          if (pulse_cnt == CNT_ONE) begin
            pulse_state_nxt = P_IDLE;
            pulse_cnt_nxt   = '0;
            pulse_mask_nxt  = '0;
          end else begin
            pulse_cnt_nxt = pulse_cnt - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read mux, sampled every clock regardless of chipselect.
  always_comb begin
    rd_nxt = '0;
    case (addr_sel)
      REG_DATA:       rd_nxt[DATA_W-1:0]  = data_reg;
      REG_PULSE_LEN:  rd_nxt[PULSE_W-1:0] = pulse_len;
      REG_PULSE_TRIG: rd_nxt[DATA_W-1:0]  = pulse_mask;
      REG_STATUS: begin
        rd_nxt[0]                = busy;
        rd_nxt[16 +: CNT_FIELD_W] = pulse_cnt[CNT_FIELD_W-1:0];
      end
      default:        ;
    endcase
  end

  // Software-visible registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg  <= RESET_VALUE;
      pulse_len <= '0;
    end else begin
      data_reg  <= data_nxt;
      pulse_len <= pulse_len_nxt;
    end
  end

  // Pulse engine state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pulse_state <= P_IDLE;
      pulse_cnt   <= '0;
      pulse_mask  <= '0;
    end else begin
      pulse_state <= pulse_state_nxt;
      pulse_cnt   <= pulse_cnt_nxt;
      pulse_mask  <= pulse_mask_nxt;
    end
  end

  // Registered read data, fixed one-cycle latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_nxt;
    end
  end

endmodule

// File: tb/tb_niosv_soc_gpo_pulse.sv
// Testbench for niosv_soc_gpo_pulse: directed scenarios plus a randomized
// bus sequence checked against a cycle-counting reference model. The model
// tracks a pulse as "mask plus end cycle" rather than a down-counter.
module tb_niosv_soc_gpo_pulse;

  localparam int unsigned DATA_W  = 4;
  localparam int unsigned PULSE_W = 16;
  localparam logic [3:0]  RV      = 4'hA;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [3:0]  out_port;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [3:0]  m_data;
  logic [3:0]  m_mask;
  logic [15:0] m_len;
  int          m_end;
  int          cyc = 0;
  logic [31:0] exp_rd;
  logic [3:0]  exp_out;

  always #5 clk = ~clk;

  niosv_soc_gpo_pulse #(
    .DATA_W(DATA_W),
    .PULSE_W(PULSE_W),
    .RESET_VALUE(RV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] eff_mask();
    return (m_end > cyc) ? m_mask : 4'h0;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    int cnt;
    cnt = (m_end > cyc) ? (m_end - cyc) : 0;
    case (a)
      3'd0:    return {28'h0, m_data};
      3'd1:    return {16'h0, m_len};
      3'd2:    return {28'h0, eff_mask()};
      3'd3:    return {cnt[15:0], 15'h0, (cnt != 0)};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_data  = RV;
    m_len   = '0;
    m_mask  = '0;
    m_end   = 0;
    exp_out = RV;
    exp_rd  = '0;
  endtask

  // Advance the model across one clock edge with the given bus inputs.
  task automatic model_edge(input logic w, input logic [2:0] a, input logic [31:0] d);
    bit active_pre;
    active_pre = (m_end > cyc);
    cyc++;
    if (w) begin
      case (a)
        3'd0: m_data = d[3:0];
        3'd1: m_len  = d[15:0];
        3'd2: if (m_len != 0 && d[3:0] != 0) begin
                if (!active_pre) m_mask = 4'h0;
                m_mask = m_mask | d[3:0];
                m_end  = cyc + int'(m_len);
              end
        3'd4: m_data = m_data | d[3:0];
        3'd5: m_data = m_data & ~d[3:0];
        default: ;
      endcase
    end
  endtask

  // Drive one bus cycle, let the edge happen, update expectations.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] d);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    exp_rd     = model_read(a);
    @(posedge clk);
    model_edge(cs & ~wn, a, d);
    #1;
    exp_out = m_data ^ eff_mask();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_port !== RV) begin bad++; $display("FAIL reset_out: got %h expected %h", out_port, RV); end
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h expected %h", readdata, 32'h0); end
    reset_n = 1'b1;
    #1;
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL release_rd: got %h expected %h", readdata, 32'h0); end
    step(1'b1, 1'b1, 3'd0, 32'h0);
    total++;
    if (readdata !== 32'h0000000A) begin bad++; $display("FAIL read_data_after_reset: got %h expected %h", readdata, 32'hA); end
    total++;
    if (out_port !== RV) begin bad++; $display("FAIL out_after_release: got %h expected %h", out_port, RV); end
  endtask

  task automatic test_data_regs();
    step(1'b1, 1'b0, 3'd0, 32'hFFFF_FFF3);
    total++;
    if (out_port !== 4'h3) begin bad++; $display("FAIL data_write: got %h expected %h", out_port, 4'h3); end
    step(1'b1, 1'b0, 3'd4, 32'h8);
    total++;
    if (out_port !== 4'hB) begin bad++; $display("FAIL outset: got %h expected %h", out_port, 4'hB); end
    step(1'b1, 1'b0, 3'd5, 32'h1);
    total++;
    if (out_port !== 4'hA) begin bad++; $display("FAIL outclear: got %h expected %h", out_port, 4'hA); end
    step(1'b1, 1'b1, 3'd4, 32'h0);
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL read_outset: got %h expected %h", readdata, 32'h0); end
    step(1'b1, 1'b1, 3'd5, 32'h0);
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL read_outclear: got %h expected %h", readdata, 32'h0); end
    step(1'b1, 1'b1, 3'd0, 32'h0);
    total++;
    if (readdata !== 32'hA) begin bad++; $display("FAIL read_data: got %h expected %h", readdata, 32'hA); end
  endtask

  task automatic test_pulse_basic();
    step(1'b1, 1'b0, 3'd1, 32'h5);
    step(1'b1, 1'b0, 3'd0, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'h1);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (out_port !== 4'h1) begin bad++; $display("FAIL pulse_active[%0d]: got %h expected %h", k, out_port, 4'h1); end
      step(1'b1, 1'b1, 3'd3, 32'h0);
      total++;
      if (readdata !== ((32'(5 - k) << 16) | 32'h1)) begin
        bad++; $display("FAIL pulse_status[%0d]: got %h expected %h", k, readdata, (32'(5 - k) << 16) | 32'h1);
      end
    end
    total++;
    if (out_port !== 4'h0) begin bad++; $display("FAIL pulse_end: got %h expected %h", out_port, 4'h0); end
    step(1'b1, 1'b1, 3'd3, 32'h0);
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL pulse_idle_status: got %h expected %h", readdata, 32'h0); end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 3'd1, 32'h4);
    step(1'b1, 1'b0, 3'd2, 32'h1);
    total++;
    if (out_port !== 4'h1) begin bad++; $display("FAIL retrig_first: got %h expected %h", out_port, 4'h1); end
    step(1'b1, 1'b1, 3'd2, 32'h0);
    total++;
    if (out_port !== 4'h1) begin bad++; $display("FAIL retrig_second: got %h expected %h", out_port, 4'h1); end
    total++;
    if (readdata !== 32'h1) begin bad++; $display("FAIL retrig_mask_early: got %h expected %h", readdata, 32'h1); end
    step(1'b1, 1'b0, 3'd2, 32'h2);
    for (int k = 0; k < 4; k++) begin
      total++;
      if (out_port !== 4'h3) begin bad++; $display("FAIL retrig_ext[%0d]: got %h expected %h", k, out_port, 4'h3); end
      step(1'b1, 1'b1, 3'd2, 32'h0);
      total++;
      if (readdata !== 32'h3) begin bad++; $display("FAIL retrig_mask[%0d]: got %h expected %h", k, readdata, 32'h3); end
    end
    total++;
    if (out_port !== 4'h0) begin bad++; $display("FAIL retrig_end: got %h expected %h", out_port, 4'h0); end
  endtask

  task automatic test_zero_len_and_abort();
    step(1'b1, 1'b0, 3'd1, 32'h0);
    step(1'b1, 1'b0, 3'd2, 32'hF);
    total++;
    if (out_port !== 4'h0) begin bad++; $display("FAIL zero_len_out: got %h expected %h", out_port, 4'h0); end
    step(1'b1, 1'b1, 3'd3, 32'h0);
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL zero_len_status: got %h expected %h", readdata, 32'h0); end
    step(1'b1, 1'b0, 3'd1, 32'd100);
    step(1'b1, 1'b0, 3'd2, 32'hF);
    for (int k = 0; k < 10; k++) begin
      total++;
      if (out_port !== 4'hF) begin bad++; $display("FAIL long_pulse[%0d]: got %h expected %h", k, out_port, 4'hF); end
      step(1'b1, 1'b1, 3'd0, 32'h0);
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (out_port !== RV) begin bad++; $display("FAIL abort_out: got %h expected %h", out_port, RV); end
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL abort_rd: got %h expected %h", readdata, 32'h0); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b1, 3'd3, 32'h0);
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL abort_status: got %h expected %h", readdata, 32'h0); end
    total++;
    if (out_port !== RV) begin bad++; $display("FAIL abort_out_after: got %h expected %h", out_port, RV); end
  endtask

  task automatic test_ignored_writes();
    step(1'b0, 1'b0, 3'd0, 32'h5);
    total++;
    if (out_port !== RV) begin bad++; $display("FAIL no_cs_write: got %h expected %h", out_port, RV); end
    step(1'b1, 1'b0, 3'd7, 32'hFFFF_FFFF);
    total++;
    if (out_port !== RV) begin bad++; $display("FAIL addr7_write: got %h expected %h", out_port, RV); end
    step(1'b1, 1'b1, 3'd7, 32'h0);
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL addr7_read: got %h expected %h", readdata, 32'h0); end
    step(1'b1, 1'b1, 3'd0, 32'h0);
    total++;
    if (readdata !== {28'h0, RV}) begin bad++; $display("FAIL data_kept: got %h expected %h", readdata, {28'h0, RV}); end
    step(1'b1, 1'b1, 3'd1, 32'h0);
    total++;
    if (readdata !== 32'h0) begin bad++; $display("FAIL len_after_reset: got %h expected %h", readdata, 32'h0); end
  endtask

  task automatic test_random();
    logic        cs;
    logic        wn;
    logic [2:0]  a;
    logic [31:0] d;
    for (int n = 0; n < 400; n++) begin
      cs = ($urandom_range(0, 3) != 0);
      wn = $urandom_range(0, 1) != 0;
      a  = 3'($urandom_range(0, 7));
      d  = $urandom;
      if (a == 3'd1) d[15:0] = 16'($urandom_range(0, 9));
      step(cs, wn, a, d);
      total++;
      if (out_port !== exp_out) begin
        bad++; $display("FAIL rand_out[%0d]: got %h expected %h", n, out_port, exp_out);
      end
      total++;
      if (readdata !== exp_rd) begin
        bad++; $display("FAIL rand_rd[%0d] addr=%0d: got %h expected %h", n, a, readdata, exp_rd);
      end
    end
  endtask

  initial begin
    test_reset();
    test_data_regs();
    test_pulse_basic();
    test_back_to_back();
    test_zero_len_and_abort();
    test_ignored_writes();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
